// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package reg_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [DEF_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] wr_reg;
        logic [DEF_DATA_W-1:0] wr_data;
    } wb_req_t;

    typedef enum logic {
        PORT_ALU = 1'b0,
        PORT_MEM = 1'b1
    } port_e;

endpackage

// File: rtl/reg_wr_fifo.sv
// Small per-requester writeback FIFO; exposes per-entry valid bits and
// destination registers so the top level can build the pending mask.
import reg_arb_pkg::*;

module reg_wr_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_reg,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [ADDR_W-1:0]             head_reg,
    output logic [DATA_W-1:0]             head_data,
    output logic [DEPTH-1:0]              entry_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_reg
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [PTR_W-1:0]  wr_idx, rd_idx, offset;
    logic              push_ok, pop_ok;
    logic [ADDR_W-1:0] reg_mem_q  [DEPTH];
    logic [ADDR_W-1:0] reg_mem_d  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign wr_idx    = wr_ptr_q[PTR_W-1:0];
    assign rd_idx    = rd_ptr_q[PTR_W-1:0];
    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_reg  = reg_mem_q[rd_idx];
    assign head_data = data_mem_q[rd_idx];

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push_ok);
        rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop_ok);
        reg_mem_d  = reg_mem_q;
        data_mem_d = data_mem_q;
        if (push_ok) begin
            reg_mem_d[wr_idx]  = push_reg;
            data_mem_d[wr_idx] = push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        reg_mem_q  <= reg_mem_d;
        data_mem_q <= data_mem_d;
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        offset    = '0;
        entry_vld = '0;
        entry_reg = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = PTR_W'(i) - rd_idx;
            entry_vld[i] = ({1'b0, offset} < count);
            entry_reg[i] = reg_mem_q[i];
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-port writeback arbiter driving the single register-file write port.
// Define REG_ARB_ROUND_ROBIN_EN for alternating grants on contention.
import reg_arb_pkg::*;

module reg_write_arbiter #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [ADDR_W-1:0]        req0_reg,
    input  logic [DATA_W-1:0]        req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [ADDR_W-1:0]        req1_reg,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        writeReg,
    output logic [DATA_W-1:0]        writeData,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic                     idle
);

    localparam int NREG = 1 << ADDR_W;

    logic                               ready_en_q, ready_en_d;
    logic                               push0, push1, pop0, pop1;
    logic                               full0, full1, empty0, empty1;
    logic [ADDR_W-1:0]                  head_reg0, head_reg1;
    logic [DATA_W-1:0]                  head_data0, head_data1;
    logic [FIFO_DEPTH-1:0]              entry_vld0, entry_vld1;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0]  entry_reg0, entry_reg1;
    logic                               grant_vld;
    port_e                              grant_port;
    logic                               regWrite_q, regWrite_d;
    logic [ADDR_W-1:0]                  writeReg_q, writeReg_d;
    logic [DATA_W-1:0]                  writeData_q, writeData_d;
`ifdef REG_ARB_ROUND_ROBIN_EN
    port_e                              last_q, last_d;
`endif

    // Ready is held low through reset and comes up on the first clock after release.
    assign ready_en_d = 1'b1;
    assign req0_ready = ready_en_q && !full0;
    assign req1_ready = ready_en_q && !full1;
    // Writes to the hardwired zero register are accepted and silently dropped.
    assign push0 = req0_valid && req0_ready && (req0_reg != ADDR_W'(ZERO_REG));
    assign push1 = req1_valid && req1_ready && (req1_reg != ADDR_W'(ZERO_REG));

    reg_wr_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo0 (
        .clk(CLK), .rst(reset), .push(push0), .push_reg(req0_reg), .push_data(req0_data),
        .pop(pop0), .full(full0), .empty(empty0), .head_reg(head_reg0),
        .head_data(head_data0), .entry_vld(entry_vld0), .entry_reg(entry_reg0)
    );

    reg_wr_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo1 (
        .clk(CLK), .rst(reset), .push(push1), .push_reg(req1_reg), .push_data(req1_data),
        .pop(pop1), .full(full1), .empty(empty1), .head_reg(head_reg1),
        .head_data(head_data1), .entry_vld(entry_vld1), .entry_reg(entry_reg1)
    );

    always_comb begin
        grant_vld  = !empty0 || !empty1;
        grant_port = PORT_ALU;
        if (!empty0 && !empty1) begin
`ifdef REG_ARB_ROUND_ROBIN_EN
            grant_port = (last_q == PORT_ALU) ? PORT_MEM : PORT_ALU;
`else
            grant_port = PORT_MEM;
`endif
        end else if (!empty1) begin
            grant_port = PORT_MEM;
        end
    end

    assign pop0 = grant_vld && (grant_port == PORT_ALU);
    assign pop1 = grant_vld && (grant_port == PORT_MEM);

    always_comb begin
        regWrite_d  = grant_vld;
        writeReg_d  = '0;
        writeData_d = '0;
        if (pop1) begin
            writeReg_d  = head_reg1;
            writeData_d = head_data1;
        end else if (pop0) begin
            writeReg_d  = head_reg0;
            writeData_d = head_data0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ready_en_q  <= 1'b0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            ready_en_q  <= ready_en_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
        end
    end

`ifdef REG_ARB_ROUND_ROBIN_EN
    assign last_d = grant_vld ? grant_port : last_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) last_q <= PORT_ALU;
        else       last_q <= last_d;
    end
`endif

    assign regWrite  = regWrite_q;
    assign writeReg  = writeReg_q;
    assign writeData = writeData_q;
    assign idle      = empty0 && empty1 && !regWrite_q;

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld0[i]) pending[entry_reg0[i]] = 1'b1;
            if (entry_vld1[i]) pending[entry_reg1[i]] = 1'b1;
        end
        if (regWrite_q) pending[writeReg_q] = 1'b1;
    end

    logic unused_nreg;
    assign unused_nreg = (NREG == 0);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a queue-based reference model.
module tb_reg_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int NREG   = 32;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_reg = '0, req1_reg = '0;
    logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
    logic              regWrite, idle;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [NREG-1:0]   pending;

    reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .pending(pending), .idle(idle)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wb_t;

    wb_t               mq0[$], mq1[$];
    bit                m_we = 0;
    logic [ADDR_W-1:0] m_reg = '0;
    logic [DATA_W-1:0] m_data = '0;
    bit                m_rdy_en = 0;
`ifdef REG_ARB_ROUND_ROBIN_EN
    bit                m_last_mem = 0;
`endif
    logic [ADDR_W-1:0] obs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] m_pending();
        logic [NREG-1:0] p = '0;
        foreach (mq0[i]) p[mq0[i].r] = 1'b1;
        foreach (mq1[i]) p[mq1[i].r] = 1'b1;
        if (m_we) p[m_reg] = 1'b1;
        return p;
    endfunction

    // Reference model: queues per port, one write leaves per clock.
    always @(posedge reset) begin
        mq0.delete();
        mq1.delete();
        m_we = 0; m_reg = '0; m_data = '0; m_rdy_en = 0;
`ifdef REG_ARB_ROUND_ROBIN_EN
        m_last_mem = 0;
`endif
    end

    always @(posedge CLK) begin
        bit a0, a1;
        int pick;
        if (!reset) begin
            a0 = m_rdy_en && (mq0.size() < DEPTH);
            a1 = m_rdy_en && (mq1.size() < DEPTH);
            pick = -1;
            if (mq0.size() > 0 && mq1.size() > 0) begin
`ifdef REG_ARB_ROUND_ROBIN_EN
                pick = m_last_mem ? 0 : 1;
`else
                pick = 1;
`endif
            end else if (mq1.size() > 0) pick = 1;
            else if (mq0.size() > 0) pick = 0;
            if (pick == 0) begin
                m_we = 1; m_reg = mq0[0].r; m_data = mq0[0].d; void'(mq0.pop_front());
            end else if (pick == 1) begin
                m_we = 1; m_reg = mq1[0].r; m_data = mq1[0].d; void'(mq1.pop_front());
            end else begin
                m_we = 0; m_reg = '0; m_data = '0;
            end
`ifdef REG_ARB_ROUND_ROBIN_EN
            if (pick >= 0) m_last_mem = (pick == 1);
`endif
            if (req0_valid && a0 && req0_reg != 0) mq0.push_back('{r: req0_reg, d: req0_data});
            if (req1_valid && a1 && req1_reg != 0) mq1.push_back('{r: req1_reg, d: req1_data});
            m_rdy_en = 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("regWrite", regWrite, m_we);
            chk("writeReg", writeReg, m_reg);
            chk("writeData", writeData, m_data);
            chk("pending", pending, m_pending());
            chk("idle", idle, (mq0.size() == 0 && mq1.size() == 0 && !m_we));
            chk("req0_ready", req0_ready, m_rdy_en && mq0.size() < DEPTH);
            chk("req1_ready", req1_ready, m_rdy_en && mq1.size() < DEPTH);
            if (regWrite) obs.push_back(writeReg);
        end
    end

    task automatic drive(input int p, input bit v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        if (p == 0) begin req0_valid = v; req0_reg = r; req0_data = d; end
        else        begin req1_valid = v; req1_reg = r; req1_data = d; end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input int p, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        int n = 0;
        drive(p, 1'b1, r, d);
        while (((p == 0) ? !req0_ready : !req1_ready) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout port%0d: ready stuck 0, want 1", p);
        end
        @(negedge CLK);
        drive(p, 1'b0, '0, '0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!idle && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            vectors++; miscompares++;
            $display("FAIL idle_timeout: idle=%0b, want 1", idle);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] p0l[$], p1l[$];

        repeat (2) @(negedge CLK);
        chk_en = 1;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_pending", pending, 0);
        chk("rst_idle", idle, 1);
        reset = 1'b0;
        @(negedge CLK);
        chk("ready0_after_reset", req0_ready, 1);
        chk("ready1_after_reset", req1_ready, 1);

        // Single write, latency and pending window.
        drive(0, 1'b1, 5'd21, 32'hFFFF0000);
        @(negedge CLK);
        drive(0, 1'b0, '0, '0);
        chk("t1_pend_N", pending[21], 1);
        chk("t1_we_N", regWrite, 0);
        @(negedge CLK);
        chk("t1_we_N1", regWrite, 1);
        chk("t1_reg_N1", writeReg, 21);
        chk("t1_data_N1", writeData, 32'hFFFF0000);
        chk("t1_pend_N1", pending[21], 1);
        @(negedge CLK);
        chk("t1_we_N2", regWrite, 0);
        chk("t1_pend_N2", pending[21], 0);
        chk("t1_idle_N2", idle, 1);

        // A port-1 write first, so the last grant is the load port.
        send(1, 5'd3, 32'h33333333);
        wait_idle();

        // Contention.
        drive(0, 1'b1, 5'd10, 32'h0000FFFF);
        drive(1, 1'b1, 5'd21, 32'h12345678);
        @(negedge CLK);
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        chk("t2_pend10", pending[10], 1);
        chk("t2_pend21", pending[21], 1);
        @(negedge CLK);
`ifdef REG_ARB_ROUND_ROBIN_EN
        chk("t2_first_reg", writeReg, 10);
        chk("t2_first_data", writeData, 32'h0000FFFF);
        @(negedge CLK);
        chk("t2_second_reg", writeReg, 21);
        chk("t2_second_data", writeData, 32'h12345678);
`else
        chk("t2_first_reg", writeReg, 21);
        chk("t2_first_data", writeData, 32'h12345678);
        @(negedge CLK);
        chk("t2_second_reg", writeReg, 10);
        chk("t2_second_data", writeData, 32'h0000FFFF);
`endif
        wait_idle();

        // Port 0 streams while port 1 stays busy.
        obs.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) send(0, ADDR_W'(11 + k), 32'hA0000000 + k);
            end
            begin
                for (int k = 0; k < 6; k++) send(1, ADDR_W'(1 + k), 32'hB0000000 + k);
            end
            begin
`ifndef REG_ARB_ROUND_ROBIN_EN
                repeat (2) @(negedge CLK);
                chk("t3_ready0_full", req0_ready, 0);
`endif
            end
        join
        wait_idle();
        foreach (obs[i]) begin
            if (obs[i] >= 11 && obs[i] <= 14) p0l.push_back(obs[i]);
            else p1l.push_back(obs[i]);
        end
        chk("t3_p0_count", p0l.size(), 4);
        chk("t3_p1_count", p1l.size(), 6);
        foreach (p0l[i]) chk("t3_p0_order", p0l[i], 11 + i);
        foreach (p1l[i]) chk("t3_p1_order", p1l[i], 1 + i);

        // Register zero.
        chk("t4_ready", req0_ready, 1);
        send(0, 5'd0, 32'hDEADBEEF);
        for (int k = 0; k < 2; k++) begin
            chk("t4_we", regWrite, 0);
            chk("t4_pend0", pending[0], 0);
            chk("t4_idle", idle, 1);
            @(negedge CLK);
        end

        // Asynchronous reset with queued work.
        drive(0, 1'b1, 5'd7, 32'hC0C0C0C0);
        drive(1, 1'b1, 5'd8, 32'hC1C1C1C1);
        @(negedge CLK);
        drive(0, 1'b1, 5'd9, 32'hC2C2C2C2);
        drive(1, 1'b1, 5'd17, 32'hC3C3C3C3);
        @(negedge CLK);
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        chk("t5_we_before", regWrite, 1);
        chk("t5_idle_before", idle, 0);
`ifndef REG_ARB_ROUND_ROBIN_EN
        chk("t5_reg_before", writeReg, 8);
`endif
        #2 reset = 1'b1;
        #1;
        chk("t5_async_we", regWrite, 0);
        chk("t5_async_reg", writeReg, 0);
        chk("t5_async_data", writeData, 0);
        chk("t5_async_pend", pending, 0);
        chk("t5_async_idle", idle, 1);
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("t5_no_stale_we", regWrite, 0);
            chk("t5_idle_after", idle, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
